// File: rtl/slime_key_arbiter.sv
// slime_key_arbiter: frame-synchronous HID keycode to slime movement command decoder.
// Define KEYARB_PLAYER2_EN to build the player 2 decoder; otherwise key2 is tied to idle.
module slime_key_arbiter #(
  parameter int         JUMP_FRAMES = 4,
  parameter logic [7:0] P1_LEFT     = 8'h50,
  parameter logic [7:0] P1_RIGHT    = 8'h4F,
  parameter logic [7:0] P1_UP       = 8'h52,
  parameter logic [7:0] P2_LEFT     = 8'h04,
  parameter logic [7:0] P2_RIGHT    = 8'h07,
  parameter logic [7:0] P2_UP       = 8'h1A
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [7:0]  keycode0,
  input  logic [7:0]  keycode1,
  output logic [15:0] key1,
  output logic [15:0] key2,
  output logic        frame_tick
);
`ifdef KEYARB_PLAYER2_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  localparam logic [15:0] CMD_IDLE  = 16'h0000;
  localparam logic [15:0] CMD_LEFT  = 16'h0050;
  localparam logic [15:0] CMD_RIGHT = 16'h004F;
  localparam logic [15:0] CMD_UP    = 16'h0052;
  typedef enum logic [1:0] {IDLE, JUMP, LOCK} jstate_e;
  logic       fclk_meta_q, fclk_sync_q, fclk_prev_q;
  logic [1:0] vld_q;
  logic       arm_q, tick_q, frame_tick_q;
  // arm_q only sets once the synchronizer has seen frame_clk low after reset,
  // so a frame_clk already high at reset release never produces a tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fclk_meta_q  <= 1'b0;
      fclk_sync_q  <= 1'b0;
      fclk_prev_q  <= 1'b0;
      vld_q        <= 2'b00;
      arm_q        <= 1'b0;
      tick_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      fclk_meta_q  <= frame_clk;
      fclk_sync_q  <= fclk_meta_q;
      fclk_prev_q  <= fclk_sync_q;
      vld_q        <= {vld_q[0], 1'b1};
      arm_q        <= arm_q | (vld_q[1] & ~fclk_sync_q);
      tick_q       <= fclk_sync_q & ~fclk_prev_q & arm_q;
      frame_tick_q <= tick_q;
    end
  end
  assign frame_tick = frame_tick_q;
  for (genvar p = 0; p < NP; p++) begin : g_pl
    logic [7:0]  c_l, c_r, c_u;
    logic        l, r, u;
    jstate_e     state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] key_q, key_d;
    assign c_l = (p == 0) ? P1_LEFT  : P2_LEFT;
    assign c_r = (p == 0) ? P1_RIGHT : P2_RIGHT;
    assign c_u = (p == 0) ? P1_UP    : P2_UP;
    assign l   = (keycode0 == c_l) || (keycode1 == c_l);
    assign r   = (keycode0 == c_r) || (keycode1 == c_r);
    assign u   = (keycode0 == c_u) || (keycode1 == c_u);
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: if (u) begin
          state_d = JUMP;
          cnt_d   = 4'(JUMP_FRAMES - 1);
        end
        JUMP: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
              else state_d = u ? LOCK : IDLE;
        LOCK: if (!u) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      key_d = (state_d == JUMP) ? CMD_UP :
              (l && r)          ? CMD_IDLE :
              l                 ? CMD_LEFT :
              r                 ? CMD_RIGHT : CMD_IDLE;
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        key_q   <= CMD_IDLE;
      end else if (tick_q) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        key_q   <= key_d;
      end
    end
  end
  assign key1 = g_pl[0].key_q;
`ifdef KEYARB_PLAYER2_EN
  assign key2 = g_pl[1].key_q;
`else
  assign key2 = CMD_IDLE;
`endif
endmodule

// File: tb/tb_slime_key_arbiter.sv
// tb_slime_key_arbiter: directed and randomized frames checked against a time-based jump model.
module tb_slime_key_arbiter;
  localparam int JF = 4;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [7:0]  k0 = 8'h00, k1 = 8'h00;
  logic [15:0] key1, key2;
  logic        frame_tick;
  int          checks = 0, errors = 0, t = 0;
  int          jend[2];
  bit          need_rel[2];
  logic [15:0] exp1, exp2;
  logic [7:0]  cl[2], cr[2], cu[2];

  slime_key_arbiter #(.JUMP_FRAMES(JF)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .keycode0(k0), .keycode1(k1),
    .key1(key1), .key2(key2), .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      jend[p] = -100;
      need_rel[p] = 0;
    end
    exp1 = 16'h0000;
    exp2 = 16'h0000;
  endtask

  // A jump covers ticks [start, start+JF); at tick start+JF a held up key must be released first.
  task automatic step(input int p, output logic [15:0] e);
    bit l, r, u, jumping;
    l = (k0 == cl[p]) || (k1 == cl[p]);
    r = (k0 == cr[p]) || (k1 == cr[p]);
    u = (k0 == cu[p]) || (k1 == cu[p]);
    jumping = 0;
    if (t < jend[p]) jumping = 1;
    else if (t == jend[p]) need_rel[p] = u;
    else if (need_rel[p]) begin
      if (!u) need_rel[p] = 0;
    end else if (u) begin
      jend[p] = t + JF;
      jumping = 1;
    end
    e = jumping ? 16'h0052 : (l && r) ? 16'h0000 : l ? 16'h0050 : r ? 16'h004F : 16'h0000;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 8))
      0: pick = 8'h50; 1: pick = 8'h4F; 2: pick = 8'h52;
      3: pick = 8'h04; 4: pick = 8'h07; 5: pick = 8'h1A;
      6: pick = 8'h00; default: pick = 8'($urandom);
    endcase
  endfunction

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input bit chk_lat);
    int n;
    logic [15:0] e;
    n = 0;
    k0 = a;
    k1 = b;
    @(negedge Clk) frame_clk = 1'b1;
    while (frame_tick !== 1'b1 && n < 12) begin
      @(negedge Clk);
      n++;
    end
    check("tick_seen", 16'(frame_tick), 16'h0001);
    if (chk_lat) check("tick_latency", 16'(n), 16'd4);
    t++;
    step(0, exp1);
    step(1, e);
`ifdef KEYARB_PLAYER2_EN
    exp2 = e;
`else
    exp2 = 16'h0000;
`endif
    check("key1", key1, exp1);
    check("key2", key2, exp2);
    @(negedge Clk);
    check("tick_pulse", 16'(frame_tick), 16'h0000);
    frame_clk = 1'b0;
    repeat (3) begin
      k0 = pick();
      k1 = pick();
      @(negedge Clk);
      check("hold_tick", 16'(frame_tick), 16'h0000);
      check("hold_key1", key1, exp1);
      check("hold_key2", key2, exp2);
    end
  endtask

  initial begin
    cl[0] = 8'h50; cr[0] = 8'h4F; cu[0] = 8'h52;
    cl[1] = 8'h04; cr[1] = 8'h07; cu[1] = 8'h1A;
    model_reset();
    k0 = 8'h50;
    repeat (3) @(negedge Clk);
    check("rst_key1", key1, 16'h0000);
    check("rst_key2", key2, 16'h0000);
    check("rst_tick", 16'(frame_tick), 16'h0000);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    frame(8'h50, 8'h00, 1);
    check("first_left", key1, 16'h0050);
    frame(8'h50, 8'h4F, 0);
    check("conflict", key1, 16'h0000);
    frame(8'h50, 8'h00, 0);
    repeat (10) frame(8'h52, 8'h00, 0);
    check("lock_idle", key1, 16'h0000);
    frame(8'h00, 8'h00, 0);
    repeat (4) frame(8'h52, 8'h00, 0);
    check("rejump", key1, 16'h0052);
    frame(8'h00, 8'h00, 0);
    repeat (6) frame(8'h52, 8'h4F, 0);
    check("jump_then_right", key1, 16'h004F);
    frame(8'h00, 8'h00, 0);
    repeat (6) frame(8'h04, 8'h1A, 0);
    frame(8'h50, 8'h1A, 0);
    frame(8'h50, 8'h50, 0);
    check("same_code", key1, 16'h0050);
    frame(8'h00, 8'h00, 0);
    frame(8'h52, 8'h00, 0);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_key1", key1, 16'h0000);
    check("async_rst_key2", key2, 16'h0000);
    model_reset();
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (8) begin
      @(negedge Clk);
      check("no_tick_at_release", 16'(frame_tick), 16'h0000);
      check("rel_key1", key1, 16'h0000);
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    frame(8'h52, 8'h00, 1);
    check("jump_after_rst", key1, 16'h0052);
    repeat (60) frame(pick(), pick(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/slime_key_arbiter.md
Name: slime_key_arbiter

Overview:
- Upstream stage of the slime movement blocks; sits between the USB keyboard keycode registers and each slime's 16-bit key input.
- Decodes the two concurrent HID keycodes into one movement command per player.
- Applies jump one-shot timing and left/right conflict resolution.
- Updates commands once per video frame so they are stable across each frame.

Parameters:
- JUMP_FRAMES, 4, number of frames the jump command is held after a fresh up press (1..15)
- P1_LEFT, 8'h50, player 1 left keycode (arrow left)
- P1_RIGHT, 8'h4F, player 1 right keycode (arrow right)
- P1_UP, 8'h52, player 1 jump keycode (arrow up)
- P2_LEFT, 8'h04, player 2 left keycode (A)
- P2_RIGHT, 8'h07, player 2 right keycode (D)
- P2_UP, 8'h1A, player 2 jump keycode (W)

Ports:
- Clk  input  1  system clock, 50 MHz
- Reset_n  input  1  asynchronous active-low reset
- frame_clk  input  1  vertical-sync frame tick; asynchronous to Clk, minimum high/low 2 Clk
- keycode0  input  8  first HID keycode, 8'h00 = none
- keycode1  input  8  second HID keycode, 8'h00 = none
- key1  output  16  player 1 command to slime 1
- key2  output  16  player 2 command to slime 2
- frame_tick  output  1  one-Clk pulse when key1/key2 update

Behaviour:
- Reset (Reset_n low, async): key1 = key2 = 16'h0000, frame_tick = 0, both jump FSMs in IDLE, counters 0, synchronizer flops 0.
- frame_clk sync: two-flop synchronizer plus edge register; rising edge produces an internal tick 3 Clk after the frame_clk rise.
- Sampling: on tick, keycode0/keycode1 are sampled together. Per player, flags L/R/U = either keycode equals that player's code.
- Outputs update on the Clk after tick; frame_tick pulses high for that same single Clk.
- Outputs are held constant between ticks, regardless of keycode activity.
- Net latency: a press is sampled at frame N and seen by the slime at its frame N+1 edge (one frame).
- Command encoding is fixed regardless of player: 16'h0050 left, 16'h004F right, 16'h0052 jump, 16'h0000 idle.
- Jump FSM (per player, advances only on tick):
  - IDLE: U=1 -> JUMP, counter = JUMP_FRAMES-1.
  - JUMP: counter>0 -> decrement; counter==0 -> LOCK if U=1, else IDLE.
  - LOCK: U=0 -> IDLE; U=1 stays (no auto-repeat).
- Command priority (evaluated from the next FSM state and flags):
  - 1. JUMP state -> 16'h0052.
  - 2. L=1 and R=1 -> 16'h0000 (conflict cancels).
  - 3. L=1 -> 16'h0050.
  - 4. R=1 -> 16'h004F.
  - 5. Otherwise 16'h0000.
- U held in LOCK does not block horizontal commands.
- Both keycodes equal the same code: treated as a single press.
- Keycodes matching no mapped code are ignored.
- Both players are decoded independently from the same two slots: P1 left + P2 up gives key1 = 0050, key2 = 0052.
- Reset mid-jump: FSM returns to IDLE immediately; a held U after reset release starts a new jump at the next tick.
- Tick coincident with reset release: ignored; the first tick is taken from the first synchronized rising edge after release.

Optional Feature:
- Macro KEYARB_PLAYER2_EN.
- Defined: player 2 decode and jump FSM are present as described.
- Undefined: player 2 logic is removed; key2 is constant 16'h0000. P2 keycodes are ignored; key1 and frame_tick behaviour is unchanged.

Test Plan:
- Reset with keycode0=8'h50 held -> key1=0000, key2=0000, frame_tick=0. After release and first frame_clk rise: frame_tick pulses about 4 Clk later, key1=0050.
- keycode0=8'h50, keycode1=8'h4F over one frame -> key1=0000. Drop keycode1 -> next tick key1=0050.
- Hold keycode0=8'h52 for 10 frames, JUMP_FRAMES=4 -> key1=0052 for ticks 1-4, 0000 for ticks 5-10. Release then press -> 0052 again for 4 ticks.
- keycode0=8'h52, keycode1=8'h4F held -> key1=0052 for 4 ticks, then 004F while both held.
- keycode0=8'h04, keycode1=8'h1A -> key1=0000, key2=0052 ×4 ticks then 0050. Without KEYARB_PLAYER2_EN: key2=0000 throughout.
- Toggle keycodes between ticks without a frame_clk edge -> key1/key2 unchanged, no frame_tick. Assert Reset_n low during JUMP -> outputs 0000 asynchronously, FSM in IDLE.
